max_reduce_uint8: RTL and testbench
===================================

MAX_REDUCE_UINT8 -- requirements
Module: max_reduce_uint8

Interface
REQ-001 Parameter WIDTH, default 8: element and result width, unsigned.
REQ-002 Parameter CNT_W, default 8: width of the element counter and argmax index.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  upstream element valid.
REQ-006 in_ready  output  1  block accepts an element this cycle.
REQ-007 in_data  input  WIDTH  unsigned element.
REQ-008 in_last  input  1  element is the final one of the current frame.
REQ-009 out_valid  output  1  frame result available.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 out_max  output  WIDTH  maximum over the frame.
REQ-012 out_idx  output  CNT_W  zero-based index of the first element equal to out_max.
REQ-013 out_count  output  CNT_W  elements in the frame, saturating.

Function
REQ-014 Input beat accepted iff in_valid && in_ready; output beat taken iff out_valid && out_ready.
REQ-015 FSM states: IDLE (no frame open), ACCUM (frame open), HOLD (result presented).
REQ-016 IDLE: in_ready=1; accepted beat loads acc=in_data, idx=0, count=1, pos=1; goes to HOLD if in_last, else ACCUM.
REQ-017 ACCUM: in_ready=1; accepted beat with in_data > acc (strict) loads acc=in_data, idx=pos; pos and count increment; goes to HOLD if in_last.
REQ-018 Ties (in_data == acc) leave acc and idx unchanged, so the earliest maximum index is reported.
REQ-019 HOLD: in_ready=0, out_valid=1, out_max/out_idx/out_count are stable; output beat returns to IDLE.
REQ-020 Latency: out_valid rises on the cycle after the in_last beat is accepted.
REQ-021 out_valid is low in IDLE and ACCUM; out_max, out_idx and out_count are don't-care unless out_valid=1.
REQ-022 No new frame is accepted in the cycle the result is taken; the first beat of the next frame is accepted no earlier than the following cycle.
REQ-023 count and pos saturate at 2^CNT_W-1; an element arriving at saturated pos that is a new maximum sets idx=2^CNT_W-1.
REQ-024 in_valid low in ACCUM holds all state with no timeout.
REQ-025 out_ready low in HOLD holds the result indefinitely.
REQ-026 in_data and in_last are ignored whenever in_ready=0.

Reset
REQ-027 Reset low forces IDLE, acc=0, idx=0, count=0, pos=0, out_valid=0 and in_ready=0 while asserted, including mid-frame and in HOLD.
REQ-028 A partial frame open at reset is discarded and produces no output.
REQ-029 in_ready returns to 1 on the first clk edge after rst_n deasserts.

Structure
REQ-030 A shared package holds the FSM state enum (IDLE, ACCUM, HOLD) and the default WIDTH and CNT_W constants.
REQ-031 The comparison of in_data against acc uses one instance of the existing combinational max_uint8 block plus a strict greater-than flag.
REQ-032 Apart from that one instance, the block is flat: FSM, acc/idx/count/pos registers and output assigns.

Verification
REQ-033 Frame 3,9,9,2 with last on 2 -> one output beat: out_max=9, out_idx=1, out_count=4, one cycle after the last beat.
REQ-034 Single-element frame 200 with last=1 from IDLE -> out_max=200, out_idx=0, out_count=1.
REQ-035 Frame 0,255,255 with out_ready=0 for 5 cycles -> result stable and in_ready=0 throughout; after out_ready=1, next frame 7 (last) -> out_max=7.
REQ-036 rst_n pulsed low after beats 50,60 -> no output; fresh frame 10,4 (last) -> out_max=10, out_idx=0, out_count=2.
REQ-037 CNT_W=3, frame of 10 elements with the maximum 99 at position 9 -> out_count=7, out_idx=7, out_max=99.
REQ-038 Random in_valid/out_ready gaps over 1000 random frames -> every result matches a reference model; no beat dropped or duplicated.

Source files
------------

// File: rtl/max_reduce_uint8_pkg.sv
// Shared types and default sizes for the frame max-reduction block.
package max_reduce_uint8_pkg;

    localparam int unsigned DefWidth = 8;
    localparam int unsigned DefCntW  = 8;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StHold
    } state_e;

endpackage

// File: rtl/max_uint8.sv
// Combinational unsigned maximum of two operands.
module max_uint8 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] max_val
);

    assign max_val = (a > b) ? a : b;

endmodule

// File: rtl/max_reduce_uint8.sv
// Streams unsigned elements per frame and reports the maximum, the index of its
// first occurrence and the saturating element count.
module max_reduce_uint8
    import max_reduce_uint8_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned CNT_W = DefCntW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_max,
    output logic [CNT_W-1:0] out_idx,
    output logic [CNT_W-1:0] out_count
);

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] pos_q, pos_d;
    logic             ready_en_q;

    logic [WIDTH-1:0] cand_max;
    logic             new_max;
    logic             accept;

    max_uint8 #(
        .WIDTH(WIDTH)
    ) u_max (
        .a      (in_data),
        .b      (acc_q),
        .max_val(cand_max)
    );

    // The max differs from acc only when in_data is strictly larger, so ties keep the older index.
    assign new_max   = (cand_max != acc_q);

    // ready_en_q holds in_ready low through reset and the first edge after release.
    assign in_ready  = ready_en_q && (state_q != StHold);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == StHold);
    assign out_max   = acc_q;
    assign out_idx   = idx_q;
    assign out_count = count_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        count_d = count_q;
        pos_d   = pos_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    acc_d   = in_data;
                    idx_d   = '0;
                    count_d = CntOne;
                    pos_d   = CntOne;
                    state_d = in_last ? StHold : StAccum;
                end
            end
            StAccum: begin
                if (accept) begin
                    if (new_max) begin
                        acc_d = cand_max;
                        idx_d = pos_q;
                    end
                    if (pos_q != CntMax) begin
                        pos_d = pos_q + CntOne;
                    end
                    if (count_q != CntMax) begin
                        count_d = count_q + CntOne;
                    end
                    if (in_last) begin
                        state_d = StHold;
                    end
                end
            end
            StHold: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            acc_q      <= '0;
            idx_q      <= '0;
            count_q    <= '0;
            pos_q      <= '0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            idx_q      <= idx_d;
            count_q    <= count_d;
            pos_q      <= pos_d;
            ready_en_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_max_reduce_uint8.sv
// Scoreboard bench: two instances (8-bit and 3-bit counters) share stimulus and are
// checked against a frame-level reference model.
module tb_max_reduce_uint8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_ready;

    logic       in_ready, out_valid;
    logic [7:0] out_max, out_idx, out_count;
    logic       in_ready3, out_valid3;
    logic [7:0] out_max3;
    logic [2:0] out_idx3, out_count3;

    typedef struct {
        logic [7:0] mx;
        int         idx8;
        int         cnt8;
        int         idx3;
        int         cnt3;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] frame_q[$];
    int         checks = 0;
    int         errors = 0;
    int         n_push = 0;
    int         n_pop  = 0;
    int         rdy_mode = 0;

    always #5 clk = ~clk;

    max_reduce_uint8 #(.WIDTH(8), .CNT_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_max  (out_max),
        .out_idx  (out_idx),
        .out_count(out_count)
    );

    max_reduce_uint8 #(.WIDTH(8), .CNT_W(3)) dut3 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready3),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid3),
        .out_ready(out_ready),
        .out_max  (out_max3),
        .out_idx  (out_idx3),
        .out_count(out_count3)
    );

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Reference: maximum of the frame, first position holding it, element count.
    function automatic exp_t model();
        exp_t e;
        int   first = -1;
        e.mx = 8'd0;
        foreach (frame_q[i]) if (frame_q[i] > e.mx) e.mx = frame_q[i];
        foreach (frame_q[i]) if (first < 0 && frame_q[i] == e.mx) first = i;
        e.idx8 = min_int(first, 255);
        e.cnt8 = min_int(frame_q.size(), 255);
        e.idx3 = min_int(first, 7);
        e.cnt3 = min_int(frame_q.size(), 7);
        return e;
    endfunction

    // Called at a negedge; returns at the negedge after the final beat is accepted.
    task automatic send_frame(input int gap_pct, input bit with_last);
        int n;
        for (int i = 0; i < frame_q.size(); i++) begin
            while (int'($urandom_range(99)) < gap_pct) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                in_last  = 1'($urandom);
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = frame_q[i];
            in_last  = with_last && (i == frame_q.size() - 1);
            n = 0;
            while (!in_ready) begin
                @(negedge clk);
                n++;
                if (n > 2000) begin
                    $display("FAIL accept_timeout actual=%0d required=%0d", n, 2000);
                    $fatal(1, "accept timeout");
                end
            end
            if (in_last) begin
                exp_q.push_back(model());
                n_push++;
            end
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", exp_q.size(), 0);
        @(negedge clk);
    endtask

    // Monitor: decides out_ready each cycle and pops the scoreboard on every output beat.
    logic       held = 1'b0;
    logic [7:0] h_max, h_idx, h_cnt;
    always @(negedge clk) begin
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            chk("in_ready_match", int'(in_ready3), int'(in_ready));
            chk("out_valid_match", int'(out_valid3), int'(out_valid));
            if (out_valid) begin
                chk("in_ready_in_hold", int'(in_ready), 0);
                if (held) begin
                    chk("hold_max", int'(out_max), int'(h_max));
                    chk("hold_idx", int'(out_idx), int'(h_idx));
                    chk("hold_cnt", int'(out_count), int'(h_cnt));
                end
                case (rdy_mode)
                    1:       out_ready = 1'b0;
                    2:       out_ready = 1'b1;
                    default: out_ready = ($urandom_range(3) != 0);
                endcase
                if (out_ready) begin
                    held = 1'b0;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_output", 1, 0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        n_pop++;
                        chk("max8", int'(out_max), int'(e.mx));
                        chk("idx8", int'(out_idx), e.idx8);
                        chk("cnt8", int'(out_count), e.cnt8);
                        chk("max3", int'(out_max3), int'(e.mx));
                        chk("idx3", int'(out_idx3), e.idx3);
                        chk("cnt3", int'(out_count3), e.cnt3);
                    end
                end else begin
                    held  = 1'b1;
                    h_max = out_max;
                    h_idx = out_idx;
                    h_cnt = out_count;
                end
            end else begin
                held      = 1'b0;
                out_ready = 1'($urandom);
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL global_timeout actual=%0d required=%0d", 1, 0);
        $fatal(1, "global timeout");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_in_ready", int'(in_ready), 0);
        chk("reset_out_valid", int'(out_valid), 0);
        rst_n = 1'b1;
        chk("release_in_ready", int'(in_ready), 0);
        @(negedge clk);
        chk("ready_after_reset", int'(in_ready), 1);

        // Ties keep the first maximum; result one cycle after the last beat.
        rdy_mode = 2;
        frame_q = '{8'd3, 8'd9, 8'd9, 8'd2};
        send_frame(0, 1'b1);
        chk("latency_valid", int'(out_valid), 1);
        chk("f1_max", int'(out_max), 9);
        chk("f1_idx", int'(out_idx), 1);
        chk("f1_cnt", int'(out_count), 4);
        drain();

        frame_q = '{8'd200};
        send_frame(0, 1'b1);
        chk("single_max", int'(out_max), 200);
        chk("single_idx", int'(out_idx), 0);
        chk("single_cnt", int'(out_count), 1);
        drain();

        // Backpressure holds the result and blocks input.
        rdy_mode = 1;
        frame_q = '{8'd0, 8'd255, 8'd255};
        send_frame(0, 1'b1);
        repeat (5) begin
            chk("bp_valid", int'(out_valid), 1);
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_max", int'(out_max), 255);
            chk("bp_idx", int'(out_idx), 1);
            @(negedge clk);
        end
        rdy_mode = 2;
        frame_q = '{8'd7};
        send_frame(0, 1'b1);
        chk("after_bp_max", int'(out_max), 7);
        drain();

        // Reset mid-frame discards the partial frame.
        frame_q = '{8'd50, 8'd60};
        send_frame(0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", int'(in_ready), 0);
        chk("midrst_out_valid", int'(out_valid), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_ready_back", int'(in_ready), 1);
        chk("midrst_no_output", int'(out_valid), 0);
        frame_q = '{8'd10, 8'd4};
        send_frame(0, 1'b1);
        chk("fresh_max", int'(out_max), 10);
        chk("fresh_idx", int'(out_idx), 0);
        chk("fresh_cnt", int'(out_count), 2);
        drain();

        // Saturating counters on the 3-bit instance.
        frame_q = {};
        for (int i = 0; i < 9; i++) frame_q.push_back(8'($urandom_range(98)));
        frame_q.push_back(8'd99);
        send_frame(0, 1'b1);
        chk("sat_cnt3", int'(out_count3), 7);
        chk("sat_idx3", int'(out_idx3), 7);
        chk("sat_max3", int'(out_max3), 99);
        drain();

        rdy_mode = 0;
        for (int f = 0; f < 1000; f++) begin
            int len;
            int hi;
            len = (f % 200 == 199) ? 300 : int'($urandom_range(1, 20));
            hi  = (f % 2 == 0) ? 255 : 15;
            frame_q = {};
            for (int i = 0; i < len; i++) frame_q.push_back(8'($urandom_range(hi)));
            send_frame(30, 1'b1);
        end
        drain();
        chk("beats_balanced", n_pop, n_push);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
